// File: rtl/pad_in_filter_pkg.sv
// pad_in_pkg: shared types and constants for the pad receive filter.
//   state_t       FSM encoding (BLANK, STABLE, CHECK)
//   GLITCH_CNT_W  width of the optional rejected-glitch counter
//                 (present only with PAD_IN_GLITCH_CNT_EN defined)
package pad_in_pkg;

    typedef enum logic [1:0] {
        BLANK  = 2'd0,
        STABLE = 2'd1,
        CHECK  = 2'd2
    } state_t;

    localparam int GLITCH_CNT_W = 16;

endpackage

// File: rtl/pad_in_filter_if.sv
// pad_in_filter_if: signal bundle between core-side logic and the pad
// receive filter.
//   en_i          receiver enable
//   drive_en_i    pad output driver active
//   pad_i         asynchronous pad readback
//   filt_len_i    extra stable cycles required before a level is accepted
//   in_o          filtered level
//   rise_o/fall_o one-cycle pulses on accepted edges
//   glitch_clr_i, glitch_cnt_o   only with PAD_IN_GLITCH_CNT_EN defined
// Modports: master = core/stimulus side, slave = filter.
interface pad_in_filter_if #(
    parameter int CNT_W = 8
);
    import pad_in_pkg::*;

    logic             en_i;
    logic             drive_en_i;
    logic             pad_i;
    logic [CNT_W-1:0] filt_len_i;
    logic             in_o;
    logic             rise_o;
    logic             fall_o;
`ifdef PAD_IN_GLITCH_CNT_EN
    logic                    glitch_clr_i;
    logic [GLITCH_CNT_W-1:0] glitch_cnt_o;

    modport master (
        output en_i, drive_en_i, pad_i, filt_len_i, glitch_clr_i,
        input  in_o, rise_o, fall_o, glitch_cnt_o
    );
    modport slave (
        input  en_i, drive_en_i, pad_i, filt_len_i, glitch_clr_i,
        output in_o, rise_o, fall_o, glitch_cnt_o
    );
`else
    modport master (
        output en_i, drive_en_i, pad_i, filt_len_i,
        input  in_o, rise_o, fall_o
    );
    modport slave (
        input  en_i, drive_en_i, pad_i, filt_len_i,
        output in_o, rise_o, fall_o
    );
`endif

endinterface

// File: rtl/pad_in_filter_sync.sv
// pad_in_sync: SYNC_STAGES-deep flop chain bringing the asynchronous pad
// readback into the clk_i domain.
//   clk_i  clock
//   rst_i  synchronous active-high reset, loads RESET_VAL into every stage
//   d_i    asynchronous input
//   q_o    synchronized output (last stage)
module pad_in_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/pad_in_filter.sv
// pad_in_filter: receive-side conditioner for a bidirectional pad.
// Synchronizes the pad readback, blanks it while the pad drives (plus a
// turnaround window), and only accepts a new level once it has differed
// from the current one for filt_len_i+1 consecutive cycles.
//   clk_i  clock
//   rst_i  synchronous active-high reset
//   bus    pad_in_filter_if.slave (en/drive/pad/filt_len in, level/pulses out)
// Optional: define PAD_IN_GLITCH_CNT_EN to add a saturating count of
// rejected glitches (bus.glitch_cnt_o, cleared by bus.glitch_clr_i).
//
// state  | meaning
// BLANK  | receiver off, pad driving, or turnaround running; in_o frozen
// STABLE | synchronized pad equals in_o
// CHECK  | synchronized pad differs; counting toward acceptance
module pad_in_filter
    import pad_in_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   CNT_W       = 8,
    parameter int   TURNAROUND  = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    pad_in_filter_if.slave   bus
);

    localparam int BLANK_W = (TURNAROUND > 0) ? $clog2(TURNAROUND + 1) : 1;

    logic               w_s;
    logic               w_block;
    state_t             r_state;
    logic               r_in;
    logic               r_rise;
    logic               r_fall;
    logic [CNT_W-1:0]   r_cnt;
    logic [BLANK_W-1:0] r_blank;

    pad_in_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (RESET_VAL)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (bus.pad_i),
        .q_o   (w_s)
    );

    assign w_block = !bus.en_i || bus.drive_en_i;

    // r_cnt holds the number of differing cycles already seen, so the
    // current differing cycle is accepted once r_cnt >= filt_len_i. In
    // STABLE it is always 0, which makes filt_len_i = 0 accept on the
    // first differing cycle without a detour through CHECK.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= BLANK;
            r_in    <= RESET_VAL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
            r_blank <= '0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (w_block) begin
                // Turnaround is armed for as long as the pad drives, so
                // the countdown starts on the cycle the driver releases.
                r_state <= BLANK;
                r_cnt   <= '0;
                r_blank <= bus.drive_en_i ? BLANK_W'(TURNAROUND) : '0;
            end else begin
                case (r_state)
                    BLANK: begin
                        if (r_blank == '0) r_state <= STABLE;
                        else               r_blank <= r_blank - 1'b1;
                    end
                    STABLE, CHECK: begin
                        if (w_s == r_in) begin
                            r_cnt   <= '0;
                            r_state <= STABLE;
                        end else if (r_cnt >= bus.filt_len_i) begin
                            r_in    <= w_s;
                            r_rise  <= w_s;
                            r_fall  <= !w_s;
                            r_cnt   <= '0;
                            r_state <= STABLE;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_state <= CHECK;
                        end
                    end
                    default: r_state <= BLANK;
                endcase
            end
        end
    end

    assign bus.in_o   = r_in;
    assign bus.rise_o = r_rise;
    assign bus.fall_o = r_fall;

`ifdef PAD_IN_GLITCH_CNT_EN
    logic                    w_reject;
    logic [GLITCH_CNT_W-1:0] r_glitch;

    // Only a CHECK->STABLE return counts; dropping into BLANK does not.
    assign w_reject = !w_block && (r_state == CHECK) && (w_s == r_in);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_glitch <= '0;
        end else if (bus.glitch_clr_i) begin
            r_glitch <= '0;
        end else if (w_reject && (r_glitch != '1)) begin
            r_glitch <= r_glitch + 1'b1;
        end
    end

    assign bus.glitch_cnt_o = r_glitch;
`endif

endmodule

// File: doc/pad_in_filter.md
Name: pad_in_filter

Overview:
- Receive-side conditioner for a bidirectional functional pad: consumes the pad readback (pad O), produces clean level + edge events for core logic.
- Synchronizes the asynchronous pad input and rejects glitches shorter than a programmable length.
- Blanks its own readback while the pad drives and for a turnaround window afterwards.
- Sits between the pad cell and peripherals (GPIO, IRQ lines).

Parameters:
- SYNC_STAGES, 2, synchronizer flops (>=2).
- CNT_W, 8, filter counter width; filt_len_i max 2^CNT_W-1.
- TURNAROUND, 2, cycles of blanking after drive_en_i falls (0 = none).
- RESET_VAL, 1'b0, reset value of synchronizer flops and filtered level.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- en_i  in  1  receiver enable
- drive_en_i  in  1  pad output driver active (inverse of pad OEN)
- pad_i  in  1  asynchronous pad readback
- filt_len_i  in  CNT_W  required extra stable cycles before level accepted
- in_o  out  1  filtered level
- rise_o  out  1  one-cycle pulse on accepted 0->1
- fall_o  out  1  one-cycle pulse on accepted 1->0

Behaviour:
- Reset (rst_i sampled high): sync flops and in_o = RESET_VAL; cnt = 0; blank counter = 0; rise_o = fall_o = 0; state = BLANK. Reset mid-count discards the pending transition.
- Synchronizer runs whenever not in reset, independent of en_i/drive_en_i. s = last sync stage.
- FSM states:
  - BLANK: entered when en_i=0 or drive_en_i=1. On drive_en_i 1->0 with en_i=1, blank counter loads TURNAROUND and counts down. Exit to STABLE when en_i=1, drive_en_i=0, blank counter = 0. In BLANK: in_o frozen, cnt = 0, no pulses.
  - STABLE: s == in_o. If s != in_o, go to CHECK with cnt = 0.
  - CHECK: s != in_o each cycle.
    - If cnt >= filt_len_i: in_o <= s; pulse rise_o/fall_o in the same cycle in_o changes; cnt = 0; go to STABLE.
    - Else cnt++.
    - If s == in_o before acceptance: glitch rejected; cnt = 0; go to STABLE.
- Acceptance condition: s differs for filt_len_i+1 consecutive cycles. filt_len_i=0 accepts on the first differing cycle.
- Latency from the first clock edge sampling the new pad value to the in_o change: SYNC_STAGES + filt_len_i cycles. All outputs are registered.
- filt_len_i may change at any time. The comparison uses >=, so lowering it below cnt accepts on the next CHECK cycle.
- Simultaneous events:
  - en_i=0 or drive_en_i=1 overrides any acceptance in the same cycle; the transition is dropped.
  - rise_o and fall_o are never both high.
- cnt cannot overflow: it is bounded by filt_len_i.

Optional Feature:
- Macro PAD_IN_GLITCH_CNT_EN.
- Defined:
  - Adds ports glitch_clr_i (in, 1) and glitch_cnt_o (out, 16).
  - glitch_cnt_o increments, saturating at 16'hFFFF, on every CHECK->STABLE rejection.
  - Resets to 0. glitch_clr_i=1 clears to 0, with priority over a simultaneous increment.
  - Entering BLANK from CHECK is not counted.
- Undefined: ports and counter absent; remaining behaviour identical.

Decomposition:
- Package pad_in_pkg: state enum (BLANK, STABLE, CHECK), GLITCH_CNT_W = 16 constant.
- Sub-module pad_in_sync: SYNC_STAGES flop chain with RESET_VAL, synchronous active-high reset.

Test Plan:
- Reset and enable: reset, en_i=1, pad_i=0, filt_len_i=3 -> in_o=0, no pulses, STABLE after 1 cycle.
- Valid edge: pad_i 0->1 held 10 cycles, filt_len_i=3 -> in_o rises exactly 5 cycles after the sampling edge; rise_o high for exactly 1 cycle.
- Glitch reject: pad_i high for 3 cycles, filt_len_i=3 -> in_o stays 0, no pulse; glitch_cnt_o=1 with macro.
- Turnaround: drive_en_i=1 with pad_i toggling, then drive_en_i falls with pad_i=1 and TURNAROUND=2 -> no pulses while driving; counting starts 2 cycles after the fall; rise_o as in the valid-edge timing from there.
- Boundaries:
  - filt_len_i=0 -> accept 2 cycles after the sampling edge.
  - filt_len_i lowered from 10 to 2 while cnt=5 -> accept next cycle.
  - filt_len_i=255 -> accept after 256 differing cycles.
- Mid-operation reset: rst_i asserted during CHECK with cnt=4 -> next cycle in_o=RESET_VAL, no pulse; glitch_cnt_o=0; glitch_clr_i concurrent with a rejection -> 0.
